// File: rtl/video_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen_pkg
//  Description : Shared types, mode constants and raster helper functions for
//                the video timing generator and the videogen consumer.
//                VideoMode describes one complete raster timing: horizontal
//                and vertical sync / porch / active widths, sync polarities
//                and the interlace flag. Field 2 of an interlaced mode uses
//                its own vertical back/front porch values.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_timing_gen_pkg;

    localparam int c_cnt_w = 12;

    typedef logic [c_cnt_w-1:0] cnt_t;

    // Interlace field flag as presented on the 'state' output.
    typedef enum logic {
        FIELD_1 = 1'b0,
        FIELD_2 = 1'b1
    } field_e;

    typedef struct packed {
        cnt_t h_sync;
        cnt_t h_back_porch;
        cnt_t h_active;
        cnt_t h_front_porch;
        cnt_t v_sync;
        cnt_t v_back_porch_1;
        cnt_t v_back_porch_2;
        cnt_t v_active;
        cnt_t v_front_porch_1;
        cnt_t v_front_porch_2;
        logic h_sync_pol;   // level driven while hsync is active
        logic v_sync_pol;   // level driven while vsync is active
        logic interlaced;
    } VideoMode;

    localparam VideoMode VMODE_1280x720 = '{
        h_sync: 12'd40, h_back_porch: 12'd220, h_active: 12'd1280, h_front_porch: 12'd110,
        v_sync: 12'd5, v_back_porch_1: 12'd20, v_back_porch_2: 12'd20, v_active: 12'd720,
        v_front_porch_1: 12'd5, v_front_porch_2: 12'd5,
        h_sync_pol: 1'b1, v_sync_pol: 1'b1, interlaced: 1'b0
    };

    localparam VideoMode VMODE_640x480 = '{
        h_sync: 12'd96, h_back_porch: 12'd48, h_active: 12'd640, h_front_porch: 12'd16,
        v_sync: 12'd2, v_back_porch_1: 12'd33, v_back_porch_2: 12'd33, v_active: 12'd480,
        v_front_porch_1: 12'd10, v_front_porch_2: 12'd10,
        h_sync_pol: 1'b0, v_sync_pol: 1'b0, interlaced: 1'b0
    };

    function automatic cnt_t h_total(input VideoMode m);
        return m.h_sync + m.h_back_porch + m.h_active + m.h_front_porch;
    endfunction

    function automatic cnt_t h_start(input VideoMode m);
        return m.h_sync + m.h_back_porch;
    endfunction

    function automatic cnt_t v_back_porch(input VideoMode m, input field_e f);
        return (f == FIELD_2) ? m.v_back_porch_2 : m.v_back_porch_1;
    endfunction

    function automatic cnt_t v_front_porch(input VideoMode m, input field_e f);
        return (f == FIELD_2) ? m.v_front_porch_2 : m.v_front_porch_1;
    endfunction

    function automatic cnt_t v_start(input VideoMode m, input field_e f);
        return m.v_sync + v_back_porch(m, f);
    endfunction

    function automatic cnt_t v_total(input VideoMode m, input field_e f);
        return v_start(m, f) + m.v_active + v_front_porch(m, f);
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_sync_delay.sv
`default_nettype none
// ============================================================================
//  Module      : video_sync_delay
//  Description : Fixed-depth shift register for the {hsync, vsync, de} bundle.
//                On reset every stage loads i_rst_value (the inactive levels),
//                so the output shows inactive levels for DEPTH clocks after
//                reset before following the input. DEPTH must be >= 1.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_rst_value     - value loaded into every stage on reset
//                i_data          - bundle to delay
//                o_data          - i_data delayed by DEPTH clocks
//  Revision    : 1.0 - initial release
// ============================================================================
module video_sync_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_rst_value,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pipe[0] <= i_rst_value;
            end else begin
                r_pipe[0] <= i_data;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pipe <= {DEPTH{i_rst_value}};
            end else begin
                r_pipe <= {r_pipe[DEPTH-2:0], i_data};
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Raster timing generator feeding videogen. Produces raster
//                position, active-area position, data enable, interlace field
//                flag and h/v sync, all registered and mutually consistent in
//                each cycle. Delayed copies of hsync/vsync/de line up with
//                videogen's registered pixel data.
//  Ports       : clock, reset         - pixel clock, sync active-high reset
//                videoMode            - requested timing (taken at frame start)
//                counterX/counterY    - raster position
//                visible_counterX/Y   - position inside the active area
//                de                   - active-video enable
//                state                - field flag (0 = field 1, 1 = field 2)
//                hsync, vsync         - sync, aligned with the counters
//                hsync_out, vsync_out,
//                de_out               - sync/de delayed by SYNC_DELAY clocks
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int SYNC_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  VideoMode    videoMode,
    output logic [11:0] counterX,
    output logic [11:0] counterY,
    output logic [11:0] visible_counterX,
    output logic [11:0] visible_counterY,
    output logic        de,
    output logic        state,
    output logic        hsync,
    output logic        vsync,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out
);

    VideoMode r_mode;
    field_e   r_state;

    // Raster advance, evaluated against the timing of the frame in progress.
    cnt_t     w_h_last;
    cnt_t     w_v_last;
    logic     w_x_wrap;
    logic     w_y_wrap;
    cnt_t     w_next_x;
    cnt_t     w_next_y;
    field_e   w_next_state;
    logic     w_load;
    VideoMode w_next_mode;

    // Outputs for the next position, evaluated against the timing that will
    // own that position (the new mode when a frame boundary is crossed).
    cnt_t     w_h_start;
    cnt_t     w_v_start;
    cnt_t     w_half;
    logic     w_h_act;
    logic     w_v_act;
    logic     w_de;
    cnt_t     w_vis_x;
    cnt_t     w_vis_y;
    logic     w_hs_on;
    logic     w_vs_on;

    logic [2:0] w_dly_in;
    logic [2:0] w_dly_rst;
    logic [2:0] w_dly_out;

    always_comb begin
        w_h_last     = h_total(r_mode) - 12'd1;
        w_v_last     = v_total(r_mode, r_state) - 12'd1;
        w_x_wrap     = (counterX == w_h_last);
        w_y_wrap     = w_x_wrap && (counterY == w_v_last);
        w_next_x     = w_x_wrap ? 12'd0 : counterX + 12'd1;
        w_next_y     = counterY;
        w_next_state = r_state;
        if (w_y_wrap) begin
            w_next_y     = 12'd0;
            w_next_state = (r_mode.interlaced && r_state == FIELD_1) ? FIELD_2 : FIELD_1;
        end else if (w_x_wrap) begin
            w_next_y = counterY + 12'd1;
        end
        // A full frame ends only when the raster returns to field 1.
        w_load      = w_y_wrap && (w_next_state == FIELD_1);
        w_next_mode = w_load ? videoMode : r_mode;
    end

    always_comb begin
        w_h_start = h_start(w_next_mode);
        w_v_start = v_start(w_next_mode, w_next_state);
        w_half    = h_total(w_next_mode) >> 1;
        w_h_act   = (w_next_x >= w_h_start) && (w_next_x < w_h_start + w_next_mode.h_active);
        w_v_act   = (w_next_y >= w_v_start) && (w_next_y < w_v_start + w_next_mode.v_active);
        w_de      = w_h_act && w_v_act;
        w_vis_x   = w_de    ? w_next_x - w_h_start : 12'd0;
        w_vis_y   = w_v_act ? w_next_y - w_v_start : 12'd0;
        w_hs_on   = (w_next_x < w_next_mode.h_sync);
        if (w_next_state == FIELD_2) begin
            // Field 2 vsync is shifted by half a line on both edges.
            w_vs_on = (w_next_mode.v_sync != 12'd0) &&
                      (((w_next_y == 12'd0) && (w_next_x >= w_half)) ||
                       ((w_next_y != 12'd0) && (w_next_y < w_next_mode.v_sync)) ||
                       ((w_next_y == w_next_mode.v_sync) && (w_next_x < w_half)));
        end else begin
            w_vs_on = (w_next_y < w_next_mode.v_sync);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mode           <= videoMode;
            r_state          <= FIELD_1;
            counterX         <= 12'd0;
            counterY         <= 12'd0;
            visible_counterX <= 12'd0;
            visible_counterY <= 12'd0;
            de               <= 1'b0;
            hsync            <= videoMode.h_sync_pol;
            vsync            <= videoMode.v_sync_pol;
        end else begin
            r_mode           <= w_next_mode;
            r_state          <= w_next_state;
            counterX         <= w_next_x;
            counterY         <= w_next_y;
            visible_counterX <= w_vis_x;
            visible_counterY <= w_vis_y;
            de               <= w_de;
            hsync            <= w_hs_on ? w_next_mode.h_sync_pol : ~w_next_mode.h_sync_pol;
            vsync            <= w_vs_on ? w_next_mode.v_sync_pol : ~w_next_mode.v_sync_pol;
        end
    end

    assign state     = r_state;
    assign w_dly_in  = {hsync, vsync, de};
    assign w_dly_rst = {~videoMode.h_sync_pol, ~videoMode.v_sync_pol, 1'b0};

    video_sync_delay #(
        .DEPTH (SYNC_DELAY),
        .WIDTH (3)
    ) u_sync_delay (
        .clk         (clock),
        .rst         (reset),
        .i_rst_value (w_dly_rst),
        .i_data      (w_dly_in),
        .o_data      (w_dly_out)
    );

    assign hsync_out = w_dly_out[2];
    assign vsync_out = w_dly_out[1];
    assign de_out    = w_dly_out[0];

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Self-checking bench for video_timing_gen. The stimulus
//                process queues hand-computed expected outputs tagged with
//                the cycle at which they must appear; a monitor pops and
//                compares them, counts sync/de activity inside windows and
//                checks the delayed outputs against the undelayed ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;
    import video_timing_gen_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    VideoMode    videoMode;
    logic [11:0] counterX, counterY, visible_counterX, visible_counterY;
    logic        de, state, hsync, vsync, hsync_out, vsync_out, de_out;

    video_timing_gen #(.SYNC_DELAY(1)) dut (
        .clock            (clock),
        .reset            (reset),
        .videoMode        (videoMode),
        .counterX         (counterX),
        .counterY         (counterY),
        .visible_counterX (visible_counterX),
        .visible_counterY (visible_counterY),
        .de               (de),
        .state            (state),
        .hsync            (hsync),
        .vsync            (vsync),
        .hsync_out        (hsync_out),
        .vsync_out        (vsync_out),
        .de_out           (de_out)
    );

    always #5 clock = ~clock;

    int   cyc   = 0;
    logic rst_q = 1'b1;
    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    typedef struct {
        int          at;
        string       name;
        logic [54:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   base    = 0;

    // Activity counting window (absolute cycles) and active sync levels.
    int   win_lo = 0, win_hi = 0;
    logic act_h = 1'b1, act_v = 1'b0;
    int   cnt_de = 0, cnt_hs = 0, cnt_vs = 0;
    int   delay_err = 0;

    function automatic VideoMode mk_mode(int hs, int hbp, int ha, int hfp, int vs, int vbp1,
                                         int vbp2, int va, int vfp1, int vfp2,
                                         logic hp, logic vp, logic il);
        VideoMode m;
        m.h_sync = hs[11:0];   m.h_back_porch = hbp[11:0];
        m.h_active = ha[11:0]; m.h_front_porch = hfp[11:0];
        m.v_sync = vs[11:0];   m.v_back_porch_1 = vbp1[11:0];
        m.v_back_porch_2 = vbp2[11:0]; m.v_active = va[11:0];
        m.v_front_porch_1 = vfp1[11:0]; m.v_front_porch_2 = vfp2[11:0];
        m.h_sync_pol = hp; m.v_sync_pol = vp; m.interlaced = il;
        return m;
    endfunction

    task automatic check_int(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // flags order: {de, state, hsync, vsync, hsync_out, vsync_out, de_out}
    task automatic expect_at(string name, int d, int x, int y, int vx, int vy, logic [6:0] f);
        exp_t e;
        e.at   = base + d;
        e.name = name;
        e.v    = {x[11:0], y[11:0], vx[11:0], vy[11:0], f};
        sb_q.push_back(e);
    endtask

    task automatic do_reset(VideoMode m);
        videoMode = m;
        reset     = 1'b1;
        @(negedge clock);
        base  = cyc;
        reset = 1'b0;
    endtask

    task automatic wait_until(int d);
        while (cyc < base + d) @(negedge clock);
    endtask

    task automatic open_window(int lo, int hi, logic ah, logic av);
        win_lo = base + lo; win_hi = base + hi;
        act_h = ah; act_v = av;
        cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [54:0] obs;
        logic        p_hs, p_vs, p_de, have_prev;
        exp_t        e;
        have_prev = 1'b0;
        p_hs = 1'b0; p_vs = 1'b0; p_de = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            obs = {counterX, counterY, visible_counterX, visible_counterY,
                   de, state, hsync, vsync, hsync_out, vsync_out, de_out};
            while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
                e = sb_q.pop_front();
                n_total++;
                if (e.at < cyc) begin
                    $display("FAIL %s: not sampled at cycle %0d (now %0d)", e.name, e.at, cyc);
                end else if (obs === e.v) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got x=%0d y=%0d vx=%0d vy=%0d flags=%b, expected x=%0d y=%0d vx=%0d vy=%0d flags=%b",
                             e.name, obs[54:43], obs[42:31], obs[30:19], obs[18:7], obs[6:0],
                             e.v[54:43], e.v[42:31], e.v[30:19], e.v[18:7], e.v[6:0]);
                end
            end
            if (cyc >= win_lo && cyc < win_hi) begin
                if (de === 1'b1)    cnt_de++;
                if (hsync === act_h) cnt_hs++;
                if (vsync === act_v) cnt_vs++;
            end
            if (have_prev && !rst_q) begin
                if (hsync_out !== p_hs || vsync_out !== p_vs || de_out !== p_de) delay_err++;
            end
            p_hs = hsync; p_vs = vsync; p_de = de;
            have_prev = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        VideoMode tm, tm2, tmi;
        // h 4/3/8/2 (total 17), v 2/3|4/5/2|2 (totals 12|13)
        tm  = mk_mode(4, 3, 8, 2, 2, 3, 4, 5, 2, 2, 1'b1, 1'b0, 1'b0);
        tm2 = mk_mode(4, 3, 8, 5, 2, 3, 4, 5, 2, 2, 1'b1, 1'b0, 1'b0);
        tmi = mk_mode(4, 3, 8, 2, 2, 3, 4, 5, 2, 2, 1'b1, 1'b0, 1'b1);
        videoMode = tm;

        // ---- progressive small mode, mode change mid-frame ----
        do_reset(tm);
        open_window(0, 204, 1'b1, 1'b0);
        expect_at("A_reset",        0,  0,  0, 0, 0, 7'b0010010);
        expect_at("A_first_clk",    1,  1,  0, 0, 0, 7'b0010100);
        expect_at("A_hsync_end",    4,  4,  0, 0, 0, 7'b0000100);
        expect_at("A_hsync_out_end",5,  5,  0, 0, 0, 7'b0000000);
        expect_at("A_line_end",    16, 16,  0, 0, 0, 7'b0000000);
        expect_at("A_x_wrap",      17,  0,  1, 0, 0, 7'b0010000);
        expect_at("A_vsync_end",   34,  0,  2, 0, 0, 7'b0011000);
        expect_at("A_pre_active",  91,  6,  5, 0, 0, 7'b0001010);
        expect_at("A_first_de",    92,  7,  5, 0, 0, 7'b1001010);
        expect_at("A_second_de",   93,  8,  5, 1, 0, 7'b1001011);
        expect_at("A_vis_y_blank",104,  2,  6, 0, 1, 7'b0011110);
        expect_at("A_old_h_total",118, 16,  6, 0, 1, 7'b0001010);
        expect_at("A_old_wrap",   119,  0,  7, 0, 2, 7'b0011010);
        expect_at("A_last_de",    167, 14,  9, 7, 4, 7'b1001011);
        expect_at("A_de_fall",    168, 15,  9, 0, 4, 7'b0001011);
        expect_at("A_frame_last", 203, 16, 11, 0, 0, 7'b0001010);
        expect_at("A_frame_wrap", 204,  0,  0, 0, 0, 7'b0010010);
        expect_at("A_new_h_total",221, 17,  0, 0, 0, 7'b0000000);
        expect_at("A_new_wrap",   224,  0,  1, 0, 0, 7'b0010000);
        wait_until(100);
        videoMode = tm2;
        wait_until(225);
        check_int("A_de_count",    cnt_de, 40);
        check_int("A_hsync_count", cnt_hs, 48);
        check_int("A_vsync_count", cnt_vs, 34);

        // ---- interlaced small mode ----
        do_reset(tmi);
        open_window(204, 425, 1'b1, 1'b0);
        expect_at("B_reset",         0,  0,  0, 0, 0, 7'b0010010);
        expect_at("B_f1_first_de",  92,  7,  5, 0, 0, 7'b1001010);
        expect_at("B_f1_last",     203, 16, 11, 0, 0, 7'b0001010);
        expect_at("B_f2_start",    204,  0,  0, 0, 0, 7'b0111010);
        expect_at("B_f2_pre_vs",   211,  7,  0, 0, 0, 7'b0101010);
        expect_at("B_f2_vs_rise",  212,  8,  0, 0, 0, 7'b0100010);
        expect_at("B_f2_vs_on",    213,  9,  0, 0, 0, 7'b0100000);
        expect_at("B_f2_vs_last",  245,  7,  2, 0, 0, 7'b0100000);
        expect_at("B_f2_vs_fall",  246,  8,  2, 0, 0, 7'b0101000);
        expect_at("B_f2_y5_blank", 296,  7,  5, 0, 0, 7'b0101010);
        expect_at("B_f2_first_de", 313,  7,  6, 0, 0, 7'b1101010);
        expect_at("B_f2_line2",    330,  7,  7, 0, 1, 7'b1101010);
        expect_at("B_f2_last",     424, 16, 12, 0, 0, 7'b0101010);
        expect_at("B_f1_again",    425,  0,  0, 0, 0, 7'b0010010);
        wait_until(430);
        check_int("B_f2_de_count",    cnt_de, 40);
        check_int("B_f2_hsync_count", cnt_hs, 52);
        check_int("B_f2_vsync_count", cnt_vs, 34);

        // ---- 640x480p60, then reset mid-frame ----
        do_reset(VMODE_640x480);
        open_window(0, 2400, 1'b0, 1'b0);
        expect_at("C_reset",          0,   0,  0,   0, 0, 7'b0000110);
        expect_at("C_hsync_last",    95,  95,  0,   0, 0, 7'b0000000);
        expect_at("C_hsync_off",     96,  96,  0,   0, 0, 7'b0010000);
        expect_at("C_hsync_out_off", 97,  97,  0,   0, 0, 7'b0010100);
        expect_at("C_x_last",       799, 799,  0,   0, 0, 7'b0010100);
        expect_at("C_x_wrap",       800,   0,  1,   0, 0, 7'b0000100);
        expect_at("C_vsync_off",   1600,   0,  2,   0, 0, 7'b0001100);
        expect_at("C_vsync_out_off",1601,  1,  2,   0, 0, 7'b0001010);
        expect_at("C_pre_de",     28143, 143, 35,   0, 0, 7'b0011110);
        expect_at("C_first_de",   28144, 144, 35,   0, 0, 7'b1011110);
        expect_at("C_second_de",  28145, 145, 35,   1, 0, 7'b1011111);
        expect_at("C_last_de_x",  28783, 783, 35, 639, 0, 7'b1011111);
        expect_at("C_de_fall",    28784, 784, 35,   0, 0, 7'b0011111);
        expect_at("C_line36_de",  28944, 144, 36,   0, 1, 7'b1011110);
        wait_until(2400);
        check_int("C_hsync_count_3l", cnt_hs, 288);
        check_int("C_vsync_count_3l", cnt_vs, 1600);
        check_int("C_de_count_3l",    cnt_de, 0);
        open_window(28800, 29600, 1'b0, 1'b0);
        wait_until(29600);
        check_int("C_de_count_line",    cnt_de, 640);
        check_int("C_hsync_count_line", cnt_hs, 96);
        wait_until(29900);
        do_reset(VMODE_640x480);
        expect_at("C_midreset",       0, 0, 0, 0, 0, 7'b0000110);
        expect_at("C_midreset_next",  1, 1, 0, 0, 0, 7'b0000000);
        wait_until(5);

        check_int("queue_drained", sb_q.size(), 0);
        check_int("delay_pipeline_errors", delay_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
